// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, fetch FSM
// encoding and the canonical NOP.
package fetch_stage_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // Redirect targets are word aligned by dropping the low two bits.
  function automatic logic [DATA_WIDTH-1:0] align_pc(input logic [DATA_WIDTH-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/IF_to_ID.sv
// IF/ID pipeline register: flush clears to a NOP bubble keeping the pc
// fields, hold freezes everything, load captures a fetched instruction.
module IF_to_ID
  import fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] if_instruction,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic [DATA_WIDTH-1:0] if_pc_plus4,
  output logic                  id_valid,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_pc_plus4
);

  // The visible reset values of the whole register are architectural,
  // so every field is reset here, data included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid       <= 1'b0;
      id_instruction <= NOP_INSTR;
      id_pc          <= '0;
      id_pc_plus4    <= PC_STEP;
    end else if (flush) begin
      id_valid       <= 1'b0;
      id_instruction <= NOP_INSTR;
    end else if (load && !hold) begin
      id_valid       <= 1'b1;
      id_instruction <= if_instruction;
      id_pc          <= if_pc;
      id_pc_plus4    <= if_pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding-request
// memory handshake and feeds the IF/ID register, with stall and redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ID_stall_i,
  input  logic                  EX_redirect_i,
  input  logic [DATA_WIDTH-1:0] EX_redirect_pc_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  output logic                  ID_valid_o,
  output logic [DATA_WIDTH-1:0] ID_instruction_o,
  output logic [DATA_WIDTH-1:0] ID_pc_o,
  output logic [DATA_WIDTH-1:0] ID_pc_plus4_o
);

  fetch_state_e          state, state_n;
  logic [DATA_WIDTH-1:0] pc, pc_n;
  logic [DATA_WIDTH-1:0] skid, skid_n;
  logic                  kill, kill_n;
  logic                  id_load, id_from_skid;
  logic [DATA_WIDTH-1:0] id_instr_in;
  logic [DATA_WIDTH-1:0] redirect_target;

  assign redirect_target  = align_pc(EX_redirect_pc_i);
  assign imem_req_valid_o = (state == REQ);
  assign imem_req_addr_o  = pc;
  assign id_instr_in      = id_from_skid ? skid : imem_rsp_data_i;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    kill_n       = kill;
    skid_n       = skid;
    id_load      = 1'b0;
    id_from_skid = 1'b0;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        // A redirect racing the handshake means the accepted address is stale.
        if (imem_req_ready_i) begin
          state_n = WAIT;
          kill_n  = EX_redirect_i;
        end
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          if (kill || EX_redirect_i) begin
            kill_n  = 1'b0;
            state_n = REQ;
          end else if (!ID_stall_i) begin
            id_load = 1'b1;
            pc_n    = pc + PC_STEP;
            state_n = REQ;
          end else begin
            skid_n  = imem_rsp_data_i;
            state_n = HOLD;
          end
        end else if (EX_redirect_i) begin
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (EX_redirect_i) begin
          state_n = REQ;
        end else if (!ID_stall_i) begin
          id_load      = 1'b1;
          id_from_skid = 1'b1;
          pc_n         = pc + PC_STEP;
          state_n      = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
    if (EX_redirect_i) pc_n = redirect_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
    end
  end

  // Skid data is only meaningful in HOLD, so it needs no reset.
  always_ff @(posedge clk) begin
    skid <= skid_n;
  end

  IF_to_ID u_if_to_id (
    .clk            (clk),
    .rst            (rst),
    .load           (id_load),
    .hold           (ID_stall_i),
    .flush          (EX_redirect_i),
    .if_instruction (id_instr_in),
    .if_pc          (pc),
    .if_pc_plus4    (pc + PC_STEP),
    .id_valid       (ID_valid_o),
    .id_instruction (ID_instruction_o),
    .id_pc          (ID_pc_o),
    .id_pc_plus4    (ID_pc_plus4_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait fetch, backpressure, stall skid,
// redirects, PC wrap and asynchronous reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_stall_i;
  logic        EX_redirect_i;
  logic [31:0] EX_redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        ID_valid_o;
  logic [31:0] ID_instruction_o;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_pc_plus4_o;

  int checks = 0;
  int errors = 0;

  logic [96:0] idv;
  logic [32:0] req;
  assign idv = {ID_valid_o, ID_instruction_o, ID_pc_o, ID_pc_plus4_o};
  assign req = {imem_req_valid_o, imem_req_addr_o};

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_stall_i       (ID_stall_i),
    .EX_redirect_i    (EX_redirect_i),
    .EX_redirect_pc_i (EX_redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .ID_valid_o       (ID_valid_o),
    .ID_instruction_o (ID_instruction_o),
    .ID_pc_o          (ID_pc_o),
    .ID_pc_plus4_o    (ID_pc_plus4_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending request, then return word w one cycle later.
  task automatic fetch_one(input logic [31:0] w);
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = w;
    step();
    imem_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ID_stall_i = 1'b0;
    EX_redirect_i = 1'b0;
    EX_redirect_pc_i = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    #3;
    checks++;
    if (req !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_req got %h exp %h", req, {1'b0, 32'h0});
    end
    checks++;
    if (idv !== {1'b0, NOP, 32'h0, 32'h4}) begin
      errors++; $display("FAIL reset_id got %h exp %h", idv, {1'b0, NOP, 32'h0, 32'h4});
    end
    step();
    rst = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL idle_req got %b exp 0", imem_req_valid_o);
    end
    step();
    checks++;
    if (req !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL first_req got %h exp %h", req, {1'b1, 32'h0});
    end
  endtask

  task automatic test_zero_wait();
    imem_req_ready_i = 1'b1;
    step();
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL zw_wait_req got %b exp 0", imem_req_valid_o);
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0010_0093;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (idv !== {1'b1, 32'h0010_0093, 32'h0, 32'h4}) begin
      errors++; $display("FAIL zw_id0 got %h exp %h", idv, {1'b1, 32'h0010_0093, 32'h0, 32'h4});
    end
    checks++;
    if (req !== {1'b1, 32'h4}) begin
      errors++; $display("FAIL zw_req4 got %h exp %h", req, {1'b1, 32'h4});
    end
    step();
    checks++;
    if (idv !== {1'b1, 32'h0010_0093, 32'h0, 32'h4}) begin
      errors++; $display("FAIL zw_id0_held got %h exp %h", idv, {1'b1, 32'h0010_0093, 32'h0, 32'h4});
    end
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0020_0113;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (idv !== {1'b1, 32'h0020_0113, 32'h4, 32'h8}) begin
      errors++; $display("FAIL zw_id1 got %h exp %h", idv, {1'b1, 32'h0020_0113, 32'h4, 32'h8});
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (req !== {1'b1, 32'h8}) begin
        errors++; $display("FAIL bp_stable%0d got %h exp %h", i, req, {1'b1, 32'h8});
      end
    end
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_accept_once got %b exp 0", imem_req_valid_o);
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0030_0193;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (idv !== {1'b1, 32'h0030_0193, 32'h8, 32'hC}) begin
      errors++; $display("FAIL bp_id got %h exp %h", idv, {1'b1, 32'h0030_0193, 32'h8, 32'hC});
    end
  endtask

  task automatic test_stall_skid();
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    ID_stall_i       = 1'b1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid_i = 1'b0;
    step();
    checks++;
    if (idv !== {1'b1, 32'h0030_0193, 32'h8, 32'hC}) begin
      errors++; $display("FAIL skid_hold_id got %h exp %h", idv, {1'b1, 32'h0030_0193, 32'h8, 32'hC});
    end
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL skid_hold_req got %b exp 0", imem_req_valid_o);
    end
    ID_stall_i = 1'b0;
    step();
    checks++;
    if (idv !== {1'b1, 32'hDEAD_BEEF, 32'hC, 32'h10}) begin
      errors++; $display("FAIL skid_release_id got %h exp %h", idv, {1'b1, 32'hDEAD_BEEF, 32'hC, 32'h10});
    end
    checks++;
    if (req !== {1'b1, 32'h10}) begin
      errors++; $display("FAIL skid_next_req got %h exp %h", req, {1'b1, 32'h10});
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    EX_redirect_i    = 1'b1;
    EX_redirect_pc_i = 32'h0000_0100;
    step();
    EX_redirect_i = 1'b0;
    checks++;
    if (idv !== {1'b0, NOP, 32'hC, 32'h10}) begin
      errors++; $display("FAIL rw_flush got %h exp %h", idv, {1'b0, NOP, 32'hC, 32'h10});
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h1234_5678;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (idv !== {1'b0, NOP, 32'hC, 32'h10}) begin
      errors++; $display("FAIL rw_drop got %h exp %h", idv, {1'b0, NOP, 32'hC, 32'h10});
    end
    checks++;
    if (req !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL rw_target_req got %h exp %h", req, {1'b1, 32'h100});
    end
    fetch_one(32'h0000_0513);
    checks++;
    if (idv !== {1'b1, 32'h0000_0513, 32'h100, 32'h104}) begin
      errors++; $display("FAIL rw_target_id got %h exp %h", idv, {1'b1, 32'h0000_0513, 32'h100, 32'h104});
    end
  endtask

  task automatic test_redirect_handshake();
    imem_req_ready_i = 1'b1;
    EX_redirect_i    = 1'b1;
    EX_redirect_pc_i = 32'h0000_0203;
    step();
    imem_req_ready_i = 1'b0;
    EX_redirect_i    = 1'b0;
    checks++;
    if ({req, ID_valid_o} !== {1'b0, 32'h200, 1'b0}) begin
      errors++; $display("FAIL rh_wait got %h exp %h", {req, ID_valid_o}, {1'b0, 32'h200, 1'b0});
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hBAD0_0013;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (idv !== {1'b0, NOP, 32'h100, 32'h104}) begin
      errors++; $display("FAIL rh_killed got %h exp %h", idv, {1'b0, NOP, 32'h100, 32'h104});
    end
    checks++;
    if (req !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL rh_target_req got %h exp %h", req, {1'b1, 32'h200});
    end
    fetch_one(32'h00A0_0093);
    checks++;
    if (idv !== {1'b1, 32'h00A0_0093, 32'h200, 32'h204}) begin
      errors++; $display("FAIL rh_target_id got %h exp %h", idv, {1'b1, 32'h00A0_0093, 32'h200, 32'h204});
    end
  endtask

  task automatic test_wrap_async_reset();
    EX_redirect_i    = 1'b1;
    EX_redirect_pc_i = 32'hFFFF_FFFE;
    step();
    EX_redirect_i = 1'b0;
    checks++;
    if ({req, ID_valid_o} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      errors++; $display("FAIL wrap_req got %h exp %h", {req, ID_valid_o}, {1'b1, 32'hFFFF_FFFC, 1'b0});
    end
    fetch_one(32'h0010_8093);
    checks++;
    if (idv !== {1'b1, 32'h0010_8093, 32'hFFFF_FFFC, 32'h0}) begin
      errors++; $display("FAIL wrap_id got %h exp %h", idv, {1'b1, 32'h0010_8093, 32'hFFFF_FFFC, 32'h0});
    end
    checks++;
    if (req !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_next_req got %h exp %h", req, {1'b1, 32'h0});
    end
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    #1;
    rst = 1'b1;
    imem_rsp_valid_i = 1'b1;
    #1;
    checks++;
    if ({req, idv} !== {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4}) begin
      errors++; $display("FAIL async_reset got %h exp %h", {req, idv}, {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4});
    end
    step();
    imem_rsp_valid_i = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if ({req, ID_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL post_reset_req got %h exp %h", {req, ID_valid_o}, {1'b1, 32'h0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_handshake();
    test_wrap_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
